uart_rx_framer: RTL and testbench

- Serial receive front end for the VRAM command path: oversamples the host UART line, deframes 8N1 characters, and emits one byte per character.
- Drives the command byte stream consumed by the VRAM controller as a single-cycle data/valid pulse. There is no back-pressure.
- Reports framing and overrun-free glitch conditions as sticky error flags.

---
 rtl/uart_rx_framer_pkg.sv | 16 +
 rtl/uart_rx_framer_if.sv | 15 +
 rtl/uart_rx_framer_sync_2ff.sv | 16 +
 rtl/uart_rx_framer.sv | 108 ++++++++++
 tb/tb_uart_rx_framer.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/uart_rx_framer_pkg.sv
// uart_rx_framer_pkg: shared state encodings, default baud divisor and the bit-vote helper.
// UART_RX_PARITY_EN (default off) switches the frame from 8N1 to 8E1.
package uart_rx_framer_pkg;
  localparam int CLKS_PER_BIT_DEFAULT = 104;
  typedef enum logic [5:0] {
    IDLE   = 6'b000001,
    START  = 6'b000010,
    DATA   = 6'b000100,
    PARITY = 6'b001000,
    STOP   = 6'b010000,
    BREAK  = 6'b100000
  } state_e;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_framer_if.sv
// uart_rx_framer_if: host line in, received byte stream and sticky error flags out.
interface uart_rx_framer_if;
  logic       rx_i;
  logic       clear_errors_i;
  logic [7:0] read_data_o;
  logic       read_valid_o;
  logic       busy_o;
  logic       error_framing_o;
  logic       error_glitch_o;
  logic       error_parity_o;
  modport master (output rx_i, clear_errors_i,
                  input read_data_o, read_valid_o, busy_o, error_framing_o, error_glitch_o, error_parity_o);
  modport slave  (input rx_i, clear_errors_i,
                  output read_data_o, read_valid_o, busy_o, error_framing_o, error_glitch_o, error_parity_o);
endinterface

// File: rtl/uart_rx_framer_sync_2ff.sv
// sync_2ff: generic two-flop synchronizer for asynchronous single-bit inputs.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clock) begin
    if (!reset) sync_q <= {2{RESET_VAL}};
    else        sync_q <= {sync_q[0], d_i};
  end
  assign q_o = sync_q[1];
endmodule

// File: rtl/uart_rx_framer.sv
// uart_rx_framer: oversampling UART receiver emitting one byte per character with sticky errors.
// Define UART_RX_PARITY_EN for 8E1 framing; the default build is 8N1 with error_parity_o tied low.
module uart_rx_framer
  import uart_rx_framer_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input logic            clock,
  input logic            reset,
  uart_rx_framer_if.slave bus
);
  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW  = $clog2(CLKS_PER_BIT);
  logic          rx_sync;
  state_e        state_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q;
  logic [1:0]    samp_q;
  logic [7:0]    shift_q, data_q;
  logic          valid_q, par_bad_q;
  logic          err_frm_q, err_glt_q, err_par_q;
  logic          at_dec, maj;
  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clock(clock),
    .reset(reset),
    .d_i  (bus.rx_i),
    .q_o  (rx_sync)
  );
  always_comb begin
    cnt_d  = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + CW'(1);
    at_dec = (cnt_q == CW'(MID + 1));
    maj    = maj3(samp_q[0], samp_q[1], rx_sync);
  end
  // The cycle that first sees the line low counts as baud tick 0, so START is entered at tick 1.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      samp_q    <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      par_bad_q <= 1'b0;
      err_frm_q <= 1'b0;
      err_glt_q <= 1'b0;
      err_par_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      cnt_q   <= cnt_d;
      if (cnt_q == CW'(MID - 1)) samp_q[0] <= rx_sync;
      if (cnt_q == CW'(MID))     samp_q[1] <= rx_sync;
      if (bus.clear_errors_i) begin
        err_frm_q <= 1'b0;
        err_glt_q <= 1'b0;
        err_par_q <= 1'b0;
      end
      case (state_q)
        IDLE: if (!rx_sync) begin
          state_q   <= START;
          cnt_q     <= CW'(1);
          par_bad_q <= 1'b0;
        end
        START: if (at_dec) begin
          state_q   <= maj ? IDLE : DATA;
          err_glt_q <= maj | (err_glt_q & ~bus.clear_errors_i);
          bit_q     <= '0;
        end
        DATA: if (at_dec) begin
          shift_q <= {maj, shift_q[7:1]};
          bit_q   <= bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_q <= PARITY;
`else
          if (bit_q == 3'd7) state_q <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (at_dec) begin
          state_q <= STOP;
          if (maj != ^shift_q) begin
            par_bad_q <= 1'b1;
            err_par_q <= 1'b1;
          end
        end
`endif
        STOP: if (at_dec) begin
          if (maj) begin
            state_q <= IDLE;
            valid_q <= ~par_bad_q;
            if (!par_bad_q) data_q <= shift_q;
          end else begin
            state_q   <= BREAK;
            err_frm_q <= 1'b1;
          end
        end
        BREAK: if (rx_sync) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign bus.read_data_o     = data_q;
  assign bus.read_valid_o    = valid_q;
  assign bus.busy_o          = (state_q != IDLE);
  assign bus.error_framing_o = err_frm_q;
  assign bus.error_glitch_o  = err_glt_q;
  assign bus.error_parity_o  = err_par_q;
endmodule

// File: tb/tb_uart_rx_framer.sv
// tb_uart_rx_framer: scoreboard bench driving 16x-oversampled frames into uart_rx_framer.
module tb_uart_rx_framer;
  localparam int CPB = 16;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   start_cyc = 0;
  int   valid_cyc = 0;
  logic prev_v = 1'b0;
  logic [7:0] exp_q[$];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  uart_rx_framer_if bus();
  uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clock) begin
    if (reset && bus.read_valid_o) begin
      pulses++;
      valid_cyc = cyc;
      if (prev_v) chk("double_pulse", {31'd0, prev_v}, 0);
      if (exp_q.size() > 0) chk("rx_data", {24'd0, bus.read_data_o}, {24'd0, exp_q.pop_front()});
      else chk("spurious_pulse", {31'd0, bus.read_valid_o}, 0);
    end
    prev_v <= bus.read_valid_o;
  end
  task automatic drive_bit(input logic v);
    bus.rx_i = v;
    repeat (CPB) @(negedge clock);
  endtask
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic bad_par);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d ^ bad_par);
`endif
    drive_bit(stop);
    bus.rx_i = 1'b1;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask
  initial begin
    int p;
    bus.rx_i = 1'b1;
    bus.clear_errors_i = 1'b0;
    idle(5);
    chk("rst_data", {24'd0, bus.read_data_o}, 0);
    chk("rst_valid", {31'd0, bus.read_valid_o}, 0);
    chk("rst_busy", {31'd0, bus.busy_o}, 0);
    chk("rst_errs", {29'd0, bus.error_framing_o, bus.error_glitch_o, bus.error_parity_o}, 0);
    reset = 1'b1;
    idle(500);
    chk("idle_busy", {31'd0, bus.busy_o}, 0);
    chk("idle_pulses", pulses, 0);
    p = pulses;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(3 * CPB);
    chk("a5_pulses", pulses - p, 1);
    chk("a5_latency", valid_cyc - start_cyc, 9 * CPB + CPB / 2 + 4);
    chk("a5_errs", {29'd0, bus.error_framing_o, bus.error_glitch_o, bus.error_parity_o}, 0);
    p = pulses;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle(3 * CPB);
    chk("b2b_pulses", pulses - p, 2);
    chk("b2b_errs", {29'd0, bus.error_framing_o, bus.error_glitch_o, bus.error_parity_o}, 0);
    p = pulses;
    bus.rx_i = 1'b0;
    idle(4);
    bus.rx_i = 1'b1;
    idle(3 * CPB);
    chk("glitch_flag", {31'd0, bus.error_glitch_o}, 1);
    chk("glitch_pulses", pulses - p, 0);
    chk("glitch_busy", {31'd0, bus.busy_o}, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    idle(3 * CPB);
    chk("3c_pulses", pulses - p, 1);
    chk("glitch_sticky", {31'd0, bus.error_glitch_o}, 1);
    bus.clear_errors_i = 1'b1;
    idle(1);
    bus.clear_errors_i = 1'b0;
    chk("glitch_clear", {31'd0, bus.error_glitch_o}, 0);
    p = pulses;
    send_frame(8'h55, 1'b0, 1'b0);
    bus.rx_i = 1'b0;
    idle(64);
    chk("brk_busy", {31'd0, bus.busy_o}, 1);
    chk("brk_framing", {31'd0, bus.error_framing_o}, 1);
    chk("brk_glitch", {31'd0, bus.error_glitch_o}, 0);
    chk("brk_pulses", pulses - p, 0);
    bus.rx_i = 1'b1;
    idle(5);
    chk("brk_release", {31'd0, bus.busy_o}, 0);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    idle(3 * CPB);
    chk("81_pulses", pulses - p, 1);
    chk("framing_sticky", {31'd0, bus.error_framing_o}, 1);
    p = pulses;
    begin
      logic [7:0] d;
      d = 8'h7E;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      bus.rx_i = d[4];
      idle(CPB / 2);
    end
    reset = 1'b0;
    idle(1);
    chk("mid_rst_busy", {31'd0, bus.busy_o}, 0);
    chk("mid_rst_framing", {31'd0, bus.error_framing_o}, 0);
    bus.rx_i = 1'b1;
    idle(3);
    reset = 1'b1;
    idle(2 * CPB);
    chk("mid_rst_pulses", pulses - p, 0);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(3 * CPB);
    chk("7e_pulses", pulses - p, 1);
    chk("7e_parity", {31'd0, bus.error_parity_o}, 0);
`ifdef UART_RX_PARITY_EN
    p = pulses;
    send_frame(8'h7E, 1'b1, 1'b1);
    idle(3 * CPB);
    chk("par_flag", {31'd0, bus.error_parity_o}, 1);
    chk("par_pulses", pulses - p, 0);
    chk("par_framing", {31'd0, bus.error_framing_o}, 0);
`endif
    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
